hilo_mdu: RTL and testbench
===========================

# hilo_mdu

Parametrised multiply/divide unit with HI/LO registers for the E stage of the five-stage MIPS pipeline. It is driven by the decoder's HILO_type code. It runs mult/multu/div/divu as multi-cycle operations with configurable latency, services mthi/mtlo/mfhi/mflo, and raises a stall request to the hazard unit while busy. An operation in flight can be cancelled by a kill input for exception/flush support.

## Interface
- WIDTH, 32: operand and HI/LO width, in bits; must be even and ≥ 8.
- MULT_CYCLES, 5: busy cycles for mult/multu; must be ≥ 1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be ≥ 1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- op  in  4  HILO_type code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mflo, 6 mfhi, 7 mtlo, 8 mthi. Codes 9–15 are treated as none.
- a  in  WIDTH  rs operand (dividend, multiplicand, or mt data).
- b  in  WIDTH  rt operand (divisor, multiplier).
- kill  in  1  cancels the in-flight operation and blocks acceptance in this cycle.
- busy  out  WIDTH-independent 1  operation in progress.
- stall  out  1  an op ≠ none is presented while busy=1; the hazard unit freezes D/E.
- rd_data  out  WIDTH  HI when op=mfhi, LO when op=mflo, otherwise 0 (combinational).
- hi, lo  out  WIDTH  architectural register contents.

## Operation
- States: IDLE (busy=0) and RUN (busy=1). A down-counter of width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1) tracks RUN.
- Acceptance: op ∈ {mult, multu, div, divu}, busy=0 and kill=0 are sampled at an edge. At that edge:
  - Operands are latched.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - The unit enters RUN.
- The result is computed from the latched operands. Its internal structure is free, provided the result is valid at commit.
- mult: signed 2·WIDTH product; HI = upper half, LO = lower half. multu: same, unsigned.
- div: signed quotient, truncated toward zero, goes to LO; remainder goes to HI and carries the dividend's sign.
  - Most-negative ÷ −1 gives LO = most-negative and HI = 0.
- divu: unsigned quotient to LO, remainder to HI.
- Divide by zero (b=0) still runs the full DIV_CYCLES, then leaves HI/LO unchanged.
- In RUN, the counter decrements every edge. At the edge where it goes 1→0, HI and LO commit and the unit returns to IDLE.
- mthi/mtlo with busy=0 and kill=0: HI or LO is written with `a` at the edge.
- Any op presented while busy=1 is ignored and asserts stall. This includes mf, whose rd_data is don't-care while stalled. The pipeline re-presents the op later.
- kill=1 while in RUN: the unit returns to IDLE at the next edge, the counter clears, and HI/LO are not modified.
- kill=1 while in IDLE: no acceptance and no mt write in that cycle.
- Reset (asserted asynchronously at any time, including mid-RUN): HI=0, LO=0, counter=0, state IDLE, busy=0. Any pending result is discarded.

## Timing
- Reset values: busy=0, stall=0, hi=0, lo=0, rd_data=0.
- Let L be the latency for the accepted op. Accept at edge E0 (op present in cycle 0). Then:
  - busy=1 in cycles 1..L.
  - HI/LO update at edge E_L and are visible in cycle L+1, with busy=0.
- Back-to-back: a new md op presented in cycle L+1 is accepted at E_{L+1}. No dead cycle.
- An op presented in cycle 0, at acceptance time, is not stalled. stall is combinational from op and busy only.
- mt write latency: 1 edge. mf read is combinational from the current HI/LO, so mthi at E0 followed by mfhi in cycle 1 returns the new value.
- kill and commit coinciding (kill=1 in cycle L): kill wins and HI/LO are unchanged.

## Test plan
- Reset: assert reset mid-RUN of a div → busy=0 immediately; hi=lo=0 after release; no later commit.
- mult a=0xFFFFFFFD, b=5 → busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu with the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- div a=0xFFFFFFF9 (−7), b=2 → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=7, b=2 → LO=3, HI=1. div b=0 → HI/LO keep their prior values.
- mthi a=0x12345678, then mfhi next cycle → rd_data=0x12345678. mtlo, then mflo → new LO returned.
- mult accepted, then in cycle 2 present mflo → stall=1 through cycle 5, stall=0 in cycle 6, rd_data = product LO. A second mult presented during busy is not accepted.
- kill in cycle 3 of a mult → busy=0 in cycle 4 and HI/LO unchanged. kill in cycle L exactly → no commit.

Source files
------------

// File: rtl/hilo_mdu.sv
// hilo_mdu: multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Rev 1.0 - initial release.
`default_nettype none

module hilo_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             kill_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0]    C_MUL_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    C_DIV_LAT = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    C_CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic             is_div_q, is_signed_q;

  logic             md_op, op_valid, div_zero;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs, q_mag, r_mag;
  logic [WIDTH-1:0] hi_d, lo_d;

  // Division works on magnitudes so that most-negative / -1 wraps naturally
  // to most-negative with a zero remainder.
  always_comb begin
    md_op    = (op_i == OP_MULT) || (op_i == OP_MULTU) || (op_i == OP_DIV) || (op_i == OP_DIVU);
    op_valid = (op_i != 4'd0) && (op_i <= OP_MTHI);
    div_zero = (b_q == '0);

    a_ext = is_signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext = is_signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = a_ext * b_ext;

    a_neg = is_signed_q & a_q[WIDTH-1];
    b_neg = is_signed_q & b_q[WIDTH-1];
    a_abs = a_neg ? (~a_q + C_ONE) : a_q;
    b_abs = b_neg ? (~b_q + C_ONE) : b_q;
    q_mag = div_zero ? '0 : (a_abs / b_abs);
    r_mag = div_zero ? '0 : (a_abs % b_abs);

    if (is_div_q) begin
      lo_d = (a_neg ^ b_neg) ? (~q_mag + C_ONE) : q_mag;
      hi_d = a_neg ? (~r_mag + C_ONE) : r_mag;
    end else begin
      lo_d = prod[WIDTH-1:0];
      hi_d = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!kill_i) begin
            if (md_op) begin
              a_q         <= a_i;
              b_q         <= b_i;
              is_div_q    <= (op_i == OP_DIV) || (op_i == OP_DIVU);
              is_signed_q <= (op_i == OP_MULT) || (op_i == OP_DIV);
              cnt_q       <= ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? C_DIV_LAT : C_MUL_LAT;
              state_q     <= S_RUN;
            end else if (op_i == OP_MTHI) begin
              hi_q <= a_i;
            end else if (op_i == OP_MTLO) begin
              lo_q <= a_i;
            end
          end
        end
        default: begin
          if (kill_i) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - C_CNT_ONE;
            if (cnt_q == C_CNT_ONE) begin
              state_q <= S_IDLE;
              // A zero divisor burns the full latency but leaves HI/LO alone.
              if (!(is_div_q && div_zero)) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
              end
            end
          end
        end
      endcase
    end
  end

  assign busy_o  = (state_q == S_RUN);
  assign stall_o = busy_o && op_valid;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  always_comb begin
    case (op_i)
      OP_MFHI: rd_data_o = hi_q;
      OP_MFLO: rd_data_o = lo_q;
      default: rd_data_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu (WIDTH=32, 5-cycle mult, 10-cycle div).
`default_nettype none

module tb_hilo_mdu;

  logic        clk;
  logic        rst_n;
  logic [3:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        kill_i;
  logic        busy_o, stall_o;
  logic [31:0] rd_data_o, hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  hilo_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .op_i(op_i), .a_i(a_i), .b_i(b_i), .kill_i(kill_i),
    .busy_o(busy_o), .stall_o(stall_o), .rd_data_o(rd_data_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a new cycle: inputs change just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Present an md op in cycle 0, then check busy in cycles 1..L and results in L+1.
  task automatic do_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int lat,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    tick(); op_i = op; a_i = a; b_i = b;
    smp(); chk({tag, "_stall0"}, {31'd0, stall_o}, 32'd0);
    for (int i = 1; i <= lat; i++) begin
      tick(); op_i = 4'd0;
      smp(); chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy_o}, 32'd1);
    end
    tick();
    smp();
    chk({tag, "_done"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_hi"}, hi_o, exp_hi);
    chk({tag, "_lo"}, lo_o, exp_lo);
  endtask

  initial begin
    rst_n = 1'b0; op_i = 4'd0; a_i = '0; b_i = '0; kill_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    smp();
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_rd", rd_data_o, 32'd0);

    do_md("mult",  4'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    do_md("multu", 4'd2, 32'hFFFF_FFFD, 32'd5, 5, 32'h0000_0004, 32'hFFFF_FFF1);
    do_md("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_md("divneg",4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    do_md("divmin",4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    do_md("divu",  4'd4, 32'd7, 32'd2, 10, 32'h0000_0001, 32'h0000_0003);
    do_md("div0",  4'd3, 32'd100, 32'd0, 10, 32'h0000_0001, 32'h0000_0003);

    // mt then mf in the following cycle
    tick(); op_i = 4'd8; a_i = 32'h1234_5678;
    tick(); op_i = 4'd6; a_i = '0;
    smp(); chk("mfhi_rd", rd_data_o, 32'h1234_5678);
    tick(); op_i = 4'd7; a_i = 32'hCAFE_BABE;
    tick(); op_i = 4'd5; a_i = '0;
    smp(); chk("mflo_rd", rd_data_o, 32'hCAFE_BABE);
    chk("mflo_hi", hi_o, 32'h1234_5678);

    // mflo presented during a mult stalls until the product is visible
    tick(); op_i = 4'd1; a_i = 32'd3; b_i = 32'd7;
    tick(); op_i = 4'd0;
    for (int c = 2; c <= 5; c++) begin
      tick(); op_i = 4'd5;
      smp(); chk($sformatf("mf_stall%0d", c), {31'd0, stall_o}, 32'd1);
    end
    tick();
    smp();
    chk("mf_stall6", {31'd0, stall_o}, 32'd0);
    chk("mf_rd6", rd_data_o, 32'd21);

    // A second mult held during busy is ignored, then accepted back-to-back
    tick(); op_i = 4'd1; a_i = 32'd9; b_i = 32'd9;
    tick(); op_i = 4'd1; a_i = 32'd2; b_i = 32'd2;
    for (int c = 2; c <= 5; c++) begin
      tick();
      smp(); chk($sformatf("m2_stall%0d", c), {31'd0, stall_o}, 32'd1);
    end
    tick();
    smp();
    chk("m2_idle6", {31'd0, busy_o}, 32'd0);
    chk("m2_lo6", lo_o, 32'd81);
    tick(); op_i = 4'd0;
    smp(); chk("m2_b2b_busy", {31'd0, busy_o}, 32'd1);
    repeat (5) tick();
    smp();
    chk("m2_lo", lo_o, 32'd4);
    chk("m2_hi", hi_o, 32'd0);

    // kill in cycle 3 of a mult
    tick(); op_i = 4'd1; a_i = 32'd5; b_i = 32'd5;
    tick(); op_i = 4'd0;
    tick(); op_i = 4'hC;
    smp(); chk("code12_nostall", {31'd0, stall_o}, 32'd0);
    tick(); op_i = 4'd0; kill_i = 1'b1;
    tick(); kill_i = 1'b0;
    smp();
    chk("kill3_busy", {31'd0, busy_o}, 32'd0);
    repeat (4) tick();
    smp(); chk("kill3_lo", lo_o, 32'd4);

    // kill coinciding with commit
    tick(); op_i = 4'd1; a_i = 32'd6; b_i = 32'd6;
    for (int c = 1; c <= 4; c++) begin tick(); op_i = 4'd0; end
    tick(); kill_i = 1'b1;
    tick(); kill_i = 1'b0;
    smp();
    chk("killL_busy", {31'd0, busy_o}, 32'd0);
    chk("killL_lo", lo_o, 32'd4);

    // kill while idle blocks mt and acceptance
    tick(); kill_i = 1'b1; op_i = 4'd8; a_i = 32'hDEAD_BEEF;
    tick(); op_i = 4'd1; a_i = 32'd3; b_i = 32'd3;
    tick(); kill_i = 1'b0; op_i = 4'd0;
    smp();
    chk("killidle_hi", hi_o, 32'd0);
    chk("killidle_busy", {31'd0, busy_o}, 32'd0);

    // asynchronous reset in the middle of a div
    tick(); op_i = 4'd4; a_i = 32'd50; b_i = 32'd7;
    tick(); op_i = 4'd0;
    tick();
    tick(); rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    tick(); rst_n = 1'b1;
    smp();
    chk("arst_lo", lo_o, 32'd0);
    repeat (12) tick();
    smp();
    chk("arst_nocommit_lo", lo_o, 32'd0);
    chk("arst_nocommit_hi", hi_o, 32'd0);
    chk("arst_idle", {31'd0, busy_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
